// File: rtl/ccu_stream_pkg.sv
// rtl/ccu_stream_pkg.sv - shared types and constants for the CCU stream arbiter
//
// Contents:
//   arb_state_e : arbiter FSM encoding (IDLE/PASS/TERM/DROP)
//   AXI_BYTE_W  : width of one stream beat
//   TERM_PAD    : byte emitted on the forced-termination beat
//   idx_w()     : index width for an N-entry one-hot vector (never below 1)

package ccu_stream_pkg;

   localparam int AXI_BYTE_W = 8;

   localparam logic [AXI_BYTE_W-1:0] TERM_PAD = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_TERM = 2'd2,
      ST_DROP = 2'd3
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ccu_stream_arb_if.sv
// rtl/ccu_stream_arb_if.sv - byte-stream bundle between the front-end sources, the arbiter and the CCU
//
// Signals:
//   s_axis_tdata  [8*N_SRC] source bytes, source i at [8i+7:8i]
//   s_axis_tvalid [N_SRC]   per-source valid
//   s_axis_tready [N_SRC]   per-source ready
//   s_axis_tlast  [N_SRC]   per-source end of packet
//   m_axis_tdata  [8]       byte to CCU
//   m_axis_tvalid           valid to CCU
//   m_axis_tready           ready from CCU
//   m_axis_tlast            end of packet to CCU
// Modports:
//   master : the arbiter (drives the CCU side and the source readies)
//   slave  : the environment (sources and CCU)

interface ccu_stream_arb_if #(
   parameter int N_SRC = 4
);
   import ccu_stream_pkg::*;

   logic [AXI_BYTE_W*N_SRC-1:0] s_axis_tdata;
   logic [N_SRC-1:0]            s_axis_tvalid;
   logic [N_SRC-1:0]            s_axis_tready;
   logic [N_SRC-1:0]            s_axis_tlast;
   logic [AXI_BYTE_W-1:0]       m_axis_tdata;
   logic                        m_axis_tvalid;
   logic                        m_axis_tready;
   logic                        m_axis_tlast;

   modport master (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      input  s_axis_tlast,
      input  m_axis_tready,
      output s_axis_tready,
      output m_axis_tdata,
      output m_axis_tvalid,
      output m_axis_tlast
   );

   modport slave (
      output s_axis_tdata,
      output s_axis_tvalid,
      output s_axis_tlast,
      output m_axis_tready,
      input  s_axis_tready,
      input  m_axis_tdata,
      input  m_axis_tvalid,
      input  m_axis_tlast
   );

endinterface

// File: rtl/ccu_stream_arb_rr_pick.sv
// rtl/ccu_stream_arb_rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req    in  [N]   request vector
//   ptr    in  [IW]  index of the last winner; search starts at ptr+1 and wraps
//   onehot out [N]   one-hot winner, 0 when no request
//   idx    out [IW]  binary index of the winner, 0 when no request

module rr_pick
   import ccu_stream_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx
);

   logic          found;
   logic [IW-1:0] cand;

   // Walk candidates ptr+1, ptr+2, ... ptr+N (mod N); the first requester
   // encountered wins. The inner loop keeps every req index constant.
   always_comb begin
      found  = 1'b0;
      cand   = '0;
      onehot = '0;
      idx    = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (cand == IW'(i))) begin
               found     = 1'b1;
               onehot[i] = 1'b1;
               idx       = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/ccu_stream_arb.sv
// rtl/ccu_stream_arb.sv - packet-level round-robin arbiter onto the CCU byte stream
//
// Parameters:
//   N_SRC   number of sources (2..8)
//   MAX_LEN bytes per packet before forced termination (2..65535)
//   TIMEOUT consecutive idle cycles mid-packet before abort (>=2)
// Ports:
//   axi_aclk    in   clock, rising edge
//   axi_areset  in   asynchronous active-high reset
//   bus         ccu_stream_arb_if.master, source and CCU stream signals
//   grant       out  [N_SRC] one-hot current owner, 0 when idle
//   err_overlen out  one-cycle pulse, packet cut at MAX_LEN
//   err_timeout out  one-cycle pulse, owner idle TIMEOUT cycles

module ccu_stream_arb
   import ccu_stream_pkg::*;
#(
   parameter int N_SRC   = 4,
   parameter int MAX_LEN = 256,
   parameter int TIMEOUT = 1023
) (
   input  logic                 axi_aclk,
   input  logic                 axi_areset,
   ccu_stream_arb_if.master     bus,
   output logic [N_SRC-1:0]     grant,
   output logic                 err_overlen,
   output logic                 err_timeout
);

   localparam int IW = idx_w(N_SRC);
   localparam int BW = $clog2(MAX_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_PASS = ST_PASS;
   localparam logic [1:0] S_TERM = ST_TERM;
   localparam logic [1:0] S_DROP = ST_DROP;

   localparam logic [BW-1:0] LAST_BEAT  = BW'(MAX_LEN - 1);
   localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] PTR_RESET  = IW'(N_SRC - 1);

   logic [1:0]            state;
   logic [IW-1:0]         gidx;
   logic [IW-1:0]         rr_ptr;
   logic [BW-1:0]         beat_cnt;
   logic [TW-1:0]         idle_cnt;

   logic [N_SRC-1:0]      pick_onehot;
   logic [IW-1:0]         pick_idx;
   logic                  pick_any;

   logic [N_SRC-1:0]      owner;
   logic                  src_valid;
   logic                  src_last;
   logic [AXI_BYTE_W-1:0] src_data;
   logic                  at_max;
   logic                  idle_expired;

   rr_pick #(
      .N (N_SRC)
   ) u_pick (
      .req    (bus.s_axis_tvalid),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   assign pick_any     = |pick_onehot;
   assign at_max       = (beat_cnt == LAST_BEAT);
   assign idle_expired = (idle_cnt == IDLE_LIMIT);

   // Select the owner's lane. gidx is only meaningful outside IDLE, and the
   // output mux below ignores these values in IDLE.
   always_comb begin
      owner     = '0;
      src_valid = 1'b0;
      src_last  = 1'b0;
      src_data  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (gidx == IW'(i)) begin
            owner[i]  = 1'b1;
            src_valid = bus.s_axis_tvalid[i];
            src_last  = bus.s_axis_tlast[i];
            src_data  = bus.s_axis_tdata[AXI_BYTE_W*i +: AXI_BYTE_W];
         end
      end
   end

   // Output mux. PASS is a pure wire from the owner to the CCU, so ready
   // and data carry no added latency. Reset forces IDLE asynchronously,
   // which drops every output in the same cycle.
   always_comb begin
      bus.s_axis_tready = '0;
      bus.m_axis_tdata  = '0;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tlast  = 1'b0;
      grant             = '0;
      case (state)
         S_PASS: begin
            bus.m_axis_tvalid = src_valid;
            bus.m_axis_tdata  = src_data;
            // Close the packet for the CCU on the last permitted beat even if
            // the source keeps going; the remainder is drained in DROP.
            bus.m_axis_tlast  = src_last | at_max;
            bus.s_axis_tready = owner & {N_SRC{bus.m_axis_tready}};
            grant             = owner;
         end
         S_TERM: begin
            bus.m_axis_tvalid = 1'b1;
            bus.m_axis_tdata  = TERM_PAD;
            bus.m_axis_tlast  = 1'b1;
            grant             = owner;
         end
         S_DROP: begin
            bus.s_axis_tready = owner;
            grant             = owner;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state       <= S_IDLE;
         gidx        <= '0;
         rr_ptr      <= PTR_RESET;
         beat_cnt    <= '0;
         idle_cnt    <= '0;
         err_overlen <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         err_overlen <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  gidx     <= pick_idx;
                  rr_ptr   <= pick_idx;
                  beat_cnt <= '0;
                  idle_cnt <= '0;
                  state    <= S_PASS;
               end
            end
            S_PASS: begin
               // Any cycle the owner presents data breaks the idle run, even
               // under CCU backpressure; this is also how a late tvalid in the
               // would-be expiry cycle cancels the timeout.
               if (src_valid) begin
                  idle_cnt <= '0;
                  if (bus.m_axis_tready) begin
                     beat_cnt <= beat_cnt + 1'b1;
                     if (src_last) begin
                        state <= S_IDLE;
                     end else if (at_max) begin
                        err_overlen <= 1'b1;
                        state       <= S_DROP;
                     end
                  end
               end else if (idle_expired) begin
                  err_timeout <= 1'b1;
                  idle_cnt    <= '0;
                  state       <= S_TERM;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            S_TERM: begin
               if (bus.m_axis_tready) begin
                  state <= S_DROP;
               end
            end
            S_DROP: begin
               // s_axis_tready is forced high here, so valid means accepted.
               if (src_valid) begin
                  idle_cnt <= '0;
                  if (src_last) begin
                     state <= S_IDLE;
                  end
               end else if (idle_expired) begin
                  err_timeout <= 1'b1;
                  idle_cnt    <= '0;
                  state       <= S_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccu_stream_arb.sv
// tb/tb_ccu_stream_arb.sv - directed self-checking bench for ccu_stream_arb (MAX_LEN=4, TIMEOUT=8)

module tb_ccu_stream_arb;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [N-1:0] grant;
   logic         err_overlen;
   logic         err_timeout;

   ccu_stream_arb_if #(.N_SRC(N)) arb_bus ();

   ccu_stream_arb #(
      .N_SRC   (N),
      .MAX_LEN (4),
      .TIMEOUT (8)
   ) dut (
      .axi_aclk    (clk),
      .axi_areset  (rst),
      .bus         (arb_bus),
      .grant       (grant),
      .err_overlen (err_overlen),
      .err_timeout (err_timeout)
   );

   int checks   = 0;
   int failures = 0;

   // Source queues: bit 8 is tlast, bits 7:0 the byte.
   logic [8:0]   src_q [N][$];
   bit           hold  [N];

   logic [7:0]   got_d [$];
   bit           got_l [$];
   logic [N-1:0] got_g [$];
   int           got_c [$];

   int           cyc;
   int           ovl_cnt, ovl_cyc;
   int           tmo_cnt, tmo_cyc;
   logic         obs_v;
   logic [7:0]   obs_d;
   logic [N-1:0] obs_rdy;

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0 && !hold[i]) begin
            arb_bus.s_axis_tvalid[i]       = 1'b1;
            arb_bus.s_axis_tdata[8*i +: 8] = src_q[i][0][7:0];
            arb_bus.s_axis_tlast[i]        = src_q[i][0][8];
         end else begin
            arb_bus.s_axis_tvalid[i]       = 1'b0;
            arb_bus.s_axis_tdata[8*i +: 8] = 8'h00;
            arb_bus.s_axis_tlast[i]        = 1'b0;
         end
      end
   endtask

   // One clock: present source heads, sample outputs, advance, pop accepted.
   task automatic step();
      logic [N-1:0] hs;
      drive();
      #1;
      obs_v   = arb_bus.m_axis_tvalid;
      obs_d   = arb_bus.m_axis_tdata;
      obs_rdy = arb_bus.s_axis_tready;
      if (arb_bus.m_axis_tvalid && arb_bus.m_axis_tready) begin
         got_d.push_back(arb_bus.m_axis_tdata);
         got_l.push_back(arb_bus.m_axis_tlast);
         got_g.push_back(grant);
         got_c.push_back(cyc);
      end
      hs = arb_bus.s_axis_tvalid & arb_bus.s_axis_tready;
      if (err_overlen) begin ovl_cnt++; ovl_cyc = cyc; end
      if (err_timeout) begin tmo_cnt++; tmo_cyc = cyc; end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
      cyc++;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         hold[i] = 1'b0;
      end
      got_d.delete(); got_l.delete(); got_g.delete(); got_c.delete();
      ovl_cnt = 0; tmo_cnt = 0; ovl_cyc = -1; tmo_cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      arb_bus.m_axis_tready = 1'b1;
      arb_bus.s_axis_tvalid = '1;
      arb_bus.s_axis_tlast  = '1;
      arb_bus.s_axis_tdata  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", grant); end
      checks++; if (arb_bus.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_mvalid got=%b exp=0", arb_bus.m_axis_tvalid); end
      checks++; if (arb_bus.m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_mlast got=%b exp=0", arb_bus.m_axis_tlast); end
      checks++; if (arb_bus.m_axis_tdata !== 8'h00) begin failures++; $display("FAIL rst_mdata got=%h exp=00", arb_bus.m_axis_tdata); end
      checks++; if (arb_bus.s_axis_tready !== 4'b0000) begin failures++; $display("FAIL rst_sready got=%b exp=0000", arb_bus.s_axis_tready); end
      checks++; if ({err_overlen, err_timeout} !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", {err_overlen, err_timeout}); end
      clear_all();
      drive();
      rst = 1'b0;
      step();
      step();
      checks++; if (obs_v !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL idle_after_rst got=v%b g%b exp=v0 g0000", obs_v, grant); end
   endtask

   task automatic test_single();
      int c0;
      clear_all();
      src_q[2].push_back({1'b0, 8'hA1});
      src_q[2].push_back({1'b0, 8'hA2});
      src_q[2].push_back({1'b1, 8'hA3});
      c0 = cyc;
      for (int k = 0; k < 12 && got_d.size() < 3; k++) step();
      checks++; if (got_d.size() != 3) begin failures++; $display("FAIL single_count got=%0d exp=3", got_d.size()); end
      if (got_d.size() == 3) begin
         checks++; if (got_c[0] != c0 + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", got_c[0], c0 + 1); end
         checks++; if ({got_d[0], got_d[1], got_d[2]} !== 24'hA1A2A3) begin failures++; $display("FAIL single_data got=%h exp=a1a2a3", {got_d[0], got_d[1], got_d[2]}); end
         checks++; if ({got_l[0], got_l[1], got_l[2]} !== 3'b001) begin failures++; $display("FAIL single_last got=%b exp=001", {got_l[0], got_l[1], got_l[2]}); end
         checks++; if (got_g[0] !== 4'b0100 || got_g[2] !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b/%b exp=0100", got_g[0], got_g[2]); end
      end
      step();
      checks++; if (grant !== 4'b0000 || obs_v !== 1'b0) begin failures++; $display("FAIL single_back_idle got=g%b v%b exp=g0000 v0", grant, obs_v); end
   endtask

   task automatic test_round_robin();
      logic [7:0]   exp_d [8] = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h02, 8'h03, 8'h42, 8'h43};
      logic [N-1:0] exp_g [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
      clear_all();
      for (int p = 0; p < 4; p++) begin
         src_q[0].push_back({p[0], 8'h00 + 8'(p)});
         src_q[1].push_back({p[0], 8'h40 + 8'(p)});
      end
      for (int k = 0; k < 40 && got_d.size() < 8; k++) step();
      checks++; if (got_d.size() != 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", got_d.size()); end
      for (int k = 0; k < 8; k++) begin
         if (k < got_d.size()) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_g[k] !== exp_g[k] || got_l[k] !== k[0]) begin
               failures++;
               $display("FAIL rr_beat%0d got=d%h g%b l%b exp=d%h g%b l%b", k, got_d[k], got_g[k], got_l[k], exp_d[k], exp_g[k], k[0]);
            end
         end
      end
      for (int p = 1; p < 4; p++) begin
         if (2 * p < got_c.size()) begin
            checks++;
            if (got_c[2*p] - got_c[2*p-1] != 2) begin failures++; $display("FAIL rr_bubble%0d got=%0d exp=2", p, got_c[2*p] - got_c[2*p-1]); end
         end
      end
   endtask

   task automatic test_overlen();
      clear_all();
      for (int b = 0; b < 6; b++) src_q[0].push_back({(b == 5), 8'hC0 + 8'(b)});
      src_q[1].push_back({1'b1, 8'hD0});
      for (int k = 0; k < 30 && got_d.size() < 5; k++) step();
      step();
      step();
      checks++; if (got_d.size() != 5) begin failures++; $display("FAIL ovl_count got=%0d exp=5", got_d.size()); end
      if (got_d.size() == 5) begin
         checks++; if ({got_d[0], got_d[1], got_d[2], got_d[3], got_d[4]} !== 40'hC0C1C2C3D0) begin failures++; $display("FAIL ovl_data got=%h exp=c0c1c2c3d0", {got_d[0], got_d[1], got_d[2], got_d[3], got_d[4]}); end
         checks++; if ({got_l[0], got_l[1], got_l[2], got_l[3], got_l[4]} !== 5'b00011) begin failures++; $display("FAIL ovl_last got=%b exp=00011", {got_l[0], got_l[1], got_l[2], got_l[3], got_l[4]}); end
         checks++; if (got_g[3] !== 4'b0001 || got_g[4] !== 4'b0010) begin failures++; $display("FAIL ovl_grant got=%b/%b exp=0001/0010", got_g[3], got_g[4]); end
         checks++; if (got_c[4] != got_c[3] + 4) begin failures++; $display("FAIL ovl_drain_gap got=%0d exp=4", got_c[4] - got_c[3]); end
         checks++; if (ovl_cyc != got_c[3] + 1) begin failures++; $display("FAIL ovl_pulse_cycle got=%0d exp=%0d", ovl_cyc, got_c[3] + 1); end
      end
      checks++; if (ovl_cnt != 1) begin failures++; $display("FAIL ovl_pulses got=%0d exp=1", ovl_cnt); end
      checks++; if (src_q[0].size() != 0) begin failures++; $display("FAIL ovl_drained got=%0d exp=0", src_q[0].size()); end
   endtask

   task automatic test_maxlen_exact();
      clear_all();
      for (int b = 0; b < 4; b++) src_q[3].push_back({(b == 3), 8'hB0 + 8'(b)});
      for (int k = 0; k < 12 && got_d.size() < 4; k++) step();
      step();
      checks++; if (got_d.size() != 4) begin failures++; $display("FAIL exact_count got=%0d exp=4", got_d.size()); end
      if (got_d.size() == 4) begin
         checks++; if ({got_l[0], got_l[1], got_l[2], got_l[3]} !== 4'b0001) begin failures++; $display("FAIL exact_last got=%b exp=0001", {got_l[0], got_l[1], got_l[2], got_l[3]}); end
         checks++; if (got_g[0] !== 4'b1000) begin failures++; $display("FAIL exact_grant got=%b exp=1000", got_g[0]); end
      end
      checks++; if (ovl_cnt != 0) begin failures++; $display("FAIL exact_no_overlen got=%0d exp=0", ovl_cnt); end
   endtask

   task automatic test_timeout();
      clear_all();
      src_q[1].push_back({1'b0, 8'hE0});
      src_q[1].push_back({1'b0, 8'hE1});
      src_q[1].push_back({1'b1, 8'hF0});
      for (int k = 0; k < 10 && got_d.size() < 2; k++) step();
      hold[1] = 1'b1;
      for (int k = 0; k < 10; k++) step();
      hold[1] = 1'b0;
      for (int k = 0; k < 4; k++) step();
      checks++; if (tmo_cnt != 1) begin failures++; $display("FAIL tmo_pulses got=%0d exp=1", tmo_cnt); end
      checks++; if (got_d.size() != 3) begin failures++; $display("FAIL tmo_count got=%0d exp=3", got_d.size()); end
      if (got_d.size() == 3) begin
         checks++; if (got_d[2] !== 8'h00 || got_l[2] !== 1'b1 || got_g[2] !== 4'b0010) begin failures++; $display("FAIL tmo_pad got=d%h l%b g%b exp=d00 l1 g0010", got_d[2], got_l[2], got_g[2]); end
         checks++; if (got_c[2] != got_c[1] + 9) begin failures++; $display("FAIL tmo_pad_cycle got=%0d exp=9", got_c[2] - got_c[1]); end
         checks++; if (tmo_cyc != got_c[1] + 9) begin failures++; $display("FAIL tmo_pulse_cycle got=%0d exp=9", tmo_cyc - got_c[1]); end
      end
      checks++; if (src_q[1].size() != 0) begin failures++; $display("FAIL tmo_late_dropped got=%0d exp=0", src_q[1].size()); end
   endtask

   task automatic test_timeout_cancel();
      clear_all();
      src_q[2].push_back({1'b0, 8'h60});
      src_q[2].push_back({1'b1, 8'h61});
      for (int k = 0; k < 10 && got_d.size() < 1; k++) step();
      hold[2] = 1'b1;
      for (int k = 0; k < 7; k++) step();
      hold[2] = 1'b0;
      for (int k = 0; k < 5 && got_d.size() < 2; k++) step();
      step();
      checks++; if (tmo_cnt != 0) begin failures++; $display("FAIL cancel_no_timeout got=%0d exp=0", tmo_cnt); end
      checks++; if (got_d.size() != 2) begin failures++; $display("FAIL cancel_count got=%0d exp=2", got_d.size()); end
      if (got_d.size() == 2) begin
         checks++; if (got_d[1] !== 8'h61 || got_l[1] !== 1'b1 || got_c[1] != got_c[0] + 8) begin failures++; $display("FAIL cancel_beat got=d%h l%b gap%0d exp=d61 l1 gap8", got_d[1], got_l[1], got_c[1] - got_c[0]); end
      end
   endtask

   task automatic test_backpressure();
      int bad;
      clear_all();
      bad = 0;
      src_q[3].push_back({1'b0, 8'h70});
      src_q[3].push_back({1'b0, 8'h71});
      src_q[3].push_back({1'b1, 8'h72});
      for (int k = 0; k < 10 && got_d.size() < 1; k++) step();
      arb_bus.m_axis_tready = 1'b0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (obs_v !== 1'b1 || obs_d !== 8'h71 || obs_rdy !== 4'b0000) bad++;
      end
      arb_bus.m_axis_tready = 1'b1;
      for (int k = 0; k < 10 && got_d.size() < 3; k++) step();
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold_cycles got=%0d bad exp=0", bad); end
      checks++; if (tmo_cnt != 0) begin failures++; $display("FAIL bp_no_timeout got=%0d exp=0", tmo_cnt); end
      checks++; if (got_d.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got_d.size()); end
      if (got_d.size() == 3) begin
         checks++; if ({got_d[0], got_d[1], got_d[2]} !== 24'h707172 || got_l[2] !== 1'b1) begin failures++; $display("FAIL bp_data got=%h l%b exp=707172 l1", {got_d[0], got_d[1], got_d[2]}, got_l[2]); end
         checks++; if (got_c[1] != got_c[0] + 51) begin failures++; $display("FAIL bp_stall_len got=%0d exp=51", got_c[1] - got_c[0]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_all();
      src_q[0].push_back({1'b0, 8'h90});
      src_q[0].push_back({1'b0, 8'h91});
      src_q[0].push_back({1'b1, 8'h92});
      for (int k = 0; k < 10 && got_d.size() < 1; k++) step();
      drive();
      rst = 1'b1;
      #1;
      checks++; if (arb_bus.m_axis_tvalid !== 1'b0 || grant !== 4'b0000 || arb_bus.s_axis_tready !== 4'b0000) begin failures++; $display("FAIL rstmid_async got=v%b g%b r%b exp=v0 g0000 r0000", arb_bus.m_axis_tvalid, grant, arb_bus.s_axis_tready); end
      @(posedge clk); #1;
      clear_all();
      drive();
      rst = 1'b0;
      src_q[0].push_back({1'b1, 8'hA0});
      src_q[1].push_back({1'b1, 8'hA8});
      for (int k = 0; k < 12 && got_d.size() < 2; k++) step();
      checks++; if (got_d.size() != 2) begin failures++; $display("FAIL rstmid_count got=%0d exp=2", got_d.size()); end
      if (got_d.size() == 2) begin
         checks++; if (got_g[0] !== 4'b0001 || got_d[0] !== 8'hA0) begin failures++; $display("FAIL rstmid_rr_ptr got=g%b d%h exp=g0001 dA0", got_g[0], got_d[0]); end
         checks++; if (got_g[1] !== 4'b0010 || got_d[1] !== 8'hA8) begin failures++; $display("FAIL rstmid_second got=g%b d%h exp=g0010 dA8", got_g[1], got_d[1]); end
      end
   endtask

   initial begin
      cyc = 0;
      rst = 1'b1;
      arb_bus.m_axis_tready = 1'b0;
      arb_bus.s_axis_tvalid = '0;
      arb_bus.s_axis_tlast  = '0;
      arb_bus.s_axis_tdata  = '0;
      clear_all();
      test_reset();
      test_single();
      test_round_robin();
      test_overlen();
      test_maxlen_exact();
      test_timeout();
      test_timeout_cancel();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
